input_debounce: RTL

Clocked, parametrised successor to the processor's combinational input port. When the control unit requests an input, the block stalls the processor through `haltIn`. It then waits for a debounced press of the confirm button, captures the switch word and extends it to the datapath width. It hands the word over with a one-cycle `valid` strobe and will not accept a second read until the button is released. It sits between the board switches and button and the register-file write mux.

---
 rtl/input_debounce_if.sv | 37 +++
 rtl/input_debounce.sv | 133 +++++++++++++
 2 files changed

// File: rtl/input_debounce_if.sv
`default_nettype none
// ============================================================================
// Module      : input_debounce_if
// Description : Switch/button/request bundle between the board, the control
//               unit and the input_debounce block.
// Revision    : 1.0
// ============================================================================
interface input_debounce_if #(
    parameter int WIDTH     = 18,
    parameter int OUT_WIDTH = 18
);
    logic [WIDTH-1:0]     switch;
    logic                 escreveInput;
    logic                 btn;
    logic                 haltIn;
    logic [OUT_WIDTH-1:0] saida;
    logic                 valid;

    modport master (
        output switch,
        output escreveInput,
        output btn,
        input  haltIn,
        input  saida,
        input  valid
    );

    modport slave (
        input  switch,
        input  escreveInput,
        input  btn,
        output haltIn,
        output saida,
        output valid
    );
endinterface
`default_nettype wire

// File: rtl/input_debounce.sv
`default_nettype none
// ============================================================================
// Module      : input_debounce
// Description : Stalls the CPU on an input request, waits for a debounced
//               confirm press, captures and extends the switch word.
//               Define INPUT_SIGNEXT_EN for sign extension (default: zero).
// Revision    : 1.0
// ============================================================================
module input_debounce #(
    parameter int WIDTH           = 18,
    parameter int OUT_WIDTH       = 18,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  wire logic       clock,
    input  wire logic       reset,
    input_debounce_if.slave bus
);
    localparam int c_cnt_w = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_WAIT_PRESS   = 2'd1,
        ST_WAIT_RELEASE = 2'd2
    } state_t;

    logic                 btn_meta_q, btn_s_q;
    logic [WIDTH-1:0]     sw_meta_q, sw_s_q;
    logic                 btn_db_q, btn_db_d;
    logic                 btn_db_dly_q;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic [c_cnt_w-1:0]   w_cnt_inc;
    state_t               state_q, state_d;
    logic [OUT_WIDTH-1:0] saida_q, saida_d;
    logic                 valid_q, valid_d;
    logic [OUT_WIDTH-1:0] w_ext;
    logic                 w_press;
    logic                 w_halt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            btn_meta_q   <= 1'b0;
            btn_s_q      <= 1'b0;
            sw_meta_q    <= '0;
            sw_s_q       <= '0;
            btn_db_q     <= 1'b0;
            btn_db_dly_q <= 1'b0;
            cnt_q        <= '0;
            state_q      <= ST_IDLE;
            saida_q      <= '0;
            valid_q      <= 1'b0;
        end else begin
            btn_meta_q   <= bus.btn;
            btn_s_q      <= btn_meta_q;
            sw_meta_q    <= bus.switch;
            sw_s_q       <= sw_meta_q;
            btn_db_q     <= btn_db_d;
            btn_db_dly_q <= btn_db_q;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            saida_q      <= saida_d;
            valid_q      <= valid_d;
        end
    end

    assign w_cnt_inc = cnt_q + 1'b1;

    // The accepted level only follows the synchronised button after it has
    // disagreed for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        btn_db_d = btn_db_q;
        cnt_d    = '0;
        if (btn_s_q != btn_db_q) begin
            if (w_cnt_inc == c_cnt_w'(DEBOUNCE_CYCLES)) begin
                btn_db_d = btn_s_q;
            end else begin
                cnt_d = w_cnt_inc;
            end
        end
    end

    assign w_press = btn_db_q & ~btn_db_dly_q;

    if (OUT_WIDTH > WIDTH) begin : g_ext
`ifdef INPUT_SIGNEXT_EN
        assign w_ext = {{(OUT_WIDTH-WIDTH){sw_s_q[WIDTH-1]}}, sw_s_q};
`else
        assign w_ext = {{(OUT_WIDTH-WIDTH){1'b0}}, sw_s_q};
`endif
    end else begin : g_noext
        assign w_ext = sw_s_q;
    end

    always_comb begin
        state_d = state_q;
        saida_d = saida_q;
        valid_d = 1'b0;
        w_halt  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                w_halt = bus.escreveInput;
                if (bus.escreveInput) begin
                    state_d = ST_WAIT_PRESS;
                end
            end
            ST_WAIT_PRESS: begin
                w_halt = 1'b1;
                if (!bus.escreveInput) begin
                    state_d = ST_IDLE;
                end else if (w_press) begin
                    saida_d = w_ext;
                    valid_d = 1'b1;
                    state_d = ST_WAIT_RELEASE;
                end
            end
            ST_WAIT_RELEASE: begin
                // The strobe cycle releases the stall so the write can retire.
                w_halt = bus.escreveInput & ~valid_q;
                if (!btn_db_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.haltIn = w_halt & ~reset;
    assign bus.saida  = saida_q;
    assign bus.valid  = valid_q;

endmodule
`default_nettype wire
